// File: rtl/dma_reg_prog_if.sv
// dma_reg_prog_if: 8237-style CPU slave bus between the processor and the DMA register file.
interface dma_reg_prog_if;
  logic       CS_N;
  logic       IOR_N;
  logic       IOW_N;
  logic [3:0] A;
  logic [7:0] DB_IN;
  logic [7:0] DB_OUT;
  logic       DB_OE;
  modport master (output CS_N, IOR_N, IOW_N, A, DB_IN, input DB_OUT, DB_OE);
  modport slave  (input CS_N, IOR_N, IOW_N, A, DB_IN, output DB_OUT, DB_OE);
endinterface

// File: rtl/dma_reg_prog.sv
// dma_reg_prog: CPU programming port and owner of the 8237-style DMA register set.
// Optional DMA_MASK_READBACK_EN makes a read at A=F return {4'hF, mask}.
module dma_reg_prog #(
  parameter int NCH = 4,
  parameter int AW  = 16
) (
  input  logic                    CLK,
  input  logic                    RESET,
  dma_reg_prog_if.slave           bus,
  input  logic [NCH-1:0]          DRQ,
  input  logic                    upd_valid,
  input  logic [1:0]              upd_ch,
  output logic                    tc_pulse,
  output logic [NCH-1:0][AW-1:0]  currAddrReg,
  output logic [NCH-1:0][AW-1:0]  currWordReg,
  output logic [NCH-1:0][AW-1:0]  baseAddrReg,
  output logic [NCH-1:0][AW-1:0]  baseWordReg,
  output logic [NCH-1:0][5:0]     modeReg,
  output logic [7:0]              commandReg,
  output logic [7:0]              requestReg,
  output logic [7:0]              maskReg,
  output logic [7:0]              tempReg,
  output logic [7:0]              statusReg
);
  logic                   iow_q, ior_q, cs_q;
  logic                   ff_q, ff_d;
  logic [NCH-1:0][AW-1:0] cur_addr_q, cur_addr_d, cur_word_q, cur_word_d;
  logic [NCH-1:0][AW-1:0] base_addr_q, base_addr_d, base_word_q, base_word_d;
  logic [NCH-1:0][5:0]    mode_q, mode_d;
  logic [7:0]             cmd_q, cmd_d;
  logic [NCH-1:0]         req_q, req_d, mask_q, mask_d, tc_q, tc_d;
  logic                   tc_pulse_q, tc_pulse_d;
  logic                   wr, rd, mclr, tc_hit;
  logic [1:0]             ch;
  logic [AW-1:0]          rd_sel;
  logic [7:0]             rd_data;
  // Commits happen on the trailing edge of a strobe that was seen with CS_N low.
  assign wr     = !iow_q && bus.IOW_N && !cs_q;
  assign rd     = !ior_q && bus.IOR_N && !cs_q;
  assign mclr   = wr && bus.A == 4'hD;
  assign ch     = bus.A[2:1];
  assign tc_hit = upd_valid && cur_word_q[upd_ch] == '0;
  always_comb begin
    cur_addr_d  = cur_addr_q;
    cur_word_d  = cur_word_q;
    base_addr_d = base_addr_q;
    base_word_d = base_word_q;
    mode_d      = mode_q;
    cmd_d       = cmd_q;
    req_d       = req_q;
    mask_d      = mask_q;
    ff_d        = (rd && !bus.A[3]) ? !ff_q : ff_q;
    tc_d        = (rd && bus.A == 4'h8) ? '0 : tc_q;
    tc_pulse_d  = tc_hit;
    if (upd_valid) begin
      cur_addr_d[upd_ch] = mode_q[upd_ch][3] ? cur_addr_q[upd_ch] - 16'd1 : cur_addr_q[upd_ch] + 16'd1;
      cur_word_d[upd_ch] = cur_word_q[upd_ch] - 16'd1;
      if (tc_hit) begin
        tc_d[upd_ch]  = 1'b1;
        req_d[upd_ch] = 1'b0;
        if (mode_q[upd_ch][2]) begin
          cur_addr_d[upd_ch] = base_addr_q[upd_ch];
          cur_word_d[upd_ch] = base_word_q[upd_ch];
        end else
          mask_d[upd_ch] = 1'b1;
      end
    end
    // CPU writes are applied last so they override same-cycle transfer updates.
    if (wr && !bus.A[3]) begin
      ff_d = !ff_q;
      if (bus.A[0]) begin
        base_word_d[ch] = ff_q ? {bus.DB_IN, base_word_q[ch][7:0]} : {base_word_q[ch][15:8], bus.DB_IN};
        cur_word_d[ch]  = ff_q ? {bus.DB_IN, cur_word_q[ch][7:0]}  : {cur_word_q[ch][15:8], bus.DB_IN};
      end else begin
        base_addr_d[ch] = ff_q ? {bus.DB_IN, base_addr_q[ch][7:0]} : {base_addr_q[ch][15:8], bus.DB_IN};
        cur_addr_d[ch]  = ff_q ? {bus.DB_IN, cur_addr_q[ch][7:0]}  : {cur_addr_q[ch][15:8], bus.DB_IN};
      end
    end
    if (wr && bus.A[3]) begin
      case (bus.A[2:0])
        3'd0: cmd_d = bus.DB_IN;
        3'd1: req_d[bus.DB_IN[1:0]] = bus.DB_IN[2];
        3'd2: mask_d[bus.DB_IN[1:0]] = bus.DB_IN[2];
        3'd3: mode_d[bus.DB_IN[1:0]] = bus.DB_IN[7:2];
        3'd4: ff_d = 1'b0;
        3'd6: mask_d = '0;
        3'd7: mask_d = bus.DB_IN[3:0];
        default: ;
      endcase
    end
    if (mclr) begin
      cur_addr_d  = '0;
      cur_word_d  = '0;
      base_addr_d = '0;
      base_word_d = '0;
      mode_d      = '0;
      cmd_d       = '0;
      req_d       = '0;
      mask_d      = '1;
      tc_d        = '0;
      ff_d        = 1'b0;
      tc_pulse_d  = 1'b0;
    end
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      iow_q       <= 1'b1;
      ior_q       <= 1'b1;
      cs_q        <= 1'b1;
      ff_q        <= 1'b0;
      cur_addr_q  <= '0;
      cur_word_q  <= '0;
      base_addr_q <= '0;
      base_word_q <= '0;
      mode_q      <= '0;
      cmd_q       <= '0;
      req_q       <= '0;
      mask_q      <= '1;
      tc_q        <= '0;
      tc_pulse_q  <= 1'b0;
    end else begin
      iow_q       <= bus.IOW_N;
      ior_q       <= bus.IOR_N;
      cs_q        <= bus.CS_N;
      ff_q        <= ff_d;
      cur_addr_q  <= cur_addr_d;
      cur_word_q  <= cur_word_d;
      base_addr_q <= base_addr_d;
      base_word_q <= base_word_d;
      mode_q      <= mode_d;
      cmd_q       <= cmd_d;
      req_q       <= req_d;
      mask_q      <= mask_d;
      tc_q        <= tc_d;
      tc_pulse_q  <= tc_pulse_d;
    end
  end
  always_comb begin
    rd_sel  = bus.A[0] ? cur_word_q[ch] : cur_addr_q[ch];
    rd_data = 8'h00;
    if (!bus.A[3])
      rd_data = ff_q ? rd_sel[15:8] : rd_sel[7:0];
    else if (bus.A == 4'h8)
      rd_data = statusReg;
    else if (bus.A == 4'hD)
      rd_data = tempReg;
`ifdef DMA_MASK_READBACK_EN
    else if (bus.A == 4'hF)
      rd_data = {4'hF, mask_q};
`else
    else
      rd_data = 8'h00;
`endif
  end
  assign bus.DB_OE  = !bus.CS_N && !bus.IOR_N;
  assign bus.DB_OUT = bus.DB_OE ? rd_data : 8'h00;
  assign tc_pulse    = tc_pulse_q;
  assign currAddrReg = cur_addr_q;
  assign currWordReg = cur_word_q;
  assign baseAddrReg = base_addr_q;
  assign baseWordReg = base_word_q;
  assign modeReg     = mode_q;
  assign commandReg  = cmd_q;
  assign requestReg  = {4'h0, req_q};
  assign maskReg     = {4'h0, mask_q};
  assign tempReg     = 8'h00;
  assign statusReg   = {DRQ, tc_q};
endmodule

// File: tb/tb_dma_reg_prog.sv
// tb_dma_reg_prog: directed-vector bench for dma_reg_prog with hand-computed expectations.
module tb_dma_reg_prog;
  logic             CLK = 1'b0;
  logic             RESET;
  logic [3:0]       DRQ;
  logic             upd_valid;
  logic [1:0]       upd_ch;
  logic             tc_pulse;
  logic [3:0][15:0] currAddrReg, currWordReg, baseAddrReg, baseWordReg;
  logic [3:0][5:0]  modeReg;
  logic [7:0]       commandReg, requestReg, maskReg, tempReg, statusReg;
  logic [7:0]       d;
  int               checks = 0;
  int               failures = 0;
  dma_reg_prog_if bus ();
  dma_reg_prog dut (
    .CLK(CLK), .RESET(RESET), .bus(bus), .DRQ(DRQ), .upd_valid(upd_valid), .upd_ch(upd_ch),
    .tc_pulse(tc_pulse), .currAddrReg(currAddrReg), .currWordReg(currWordReg),
    .baseAddrReg(baseAddrReg), .baseWordReg(baseWordReg), .modeReg(modeReg),
    .commandReg(commandReg), .requestReg(requestReg), .maskReg(maskReg),
    .tempReg(tempReg), .statusReg(statusReg)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cpu_wr(input logic [3:0] a, input logic [7:0] v);
    @(negedge CLK) bus.A = a; bus.DB_IN = v; bus.CS_N = 1'b0; bus.IOW_N = 1'b0;
    @(negedge CLK);
    @(negedge CLK) bus.IOW_N = 1'b1;
    @(negedge CLK) bus.CS_N = 1'b1;
  endtask
  task automatic cpu_rd(input logic [3:0] a, output logic [7:0] v);
    @(negedge CLK) bus.A = a; bus.CS_N = 1'b0; bus.IOR_N = 1'b0;
    @(negedge CLK) v = bus.DB_OUT; bus.IOR_N = 1'b1;
    @(negedge CLK) bus.CS_N = 1'b1;
  endtask
  task automatic upd(input logic [1:0] c);
    @(negedge CLK) upd_valid = 1'b1; upd_ch = c;
    @(negedge CLK) upd_valid = 1'b0;
  endtask
  initial begin
    RESET = 1'b1; DRQ = 4'hA; upd_valid = 1'b0; upd_ch = 2'd0;
    bus.CS_N = 1'b1; bus.IOR_N = 1'b1; bus.IOW_N = 1'b1; bus.A = 4'h0; bus.DB_IN = 8'h00;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    check("rst_mask", maskReg, 8'h0F);
    check("rst_req", requestReg, 8'h00);
    check("rst_tcp", tc_pulse, 1'b0);
    check("rst_dbout", {bus.DB_OE, bus.DB_OUT}, 9'h000);
    cpu_rd(4'h8, d);
    check("rst_status", d, 8'hA0);
    cpu_wr(4'hC, 8'h00);
    cpu_wr(4'h2, 8'h34);
    cpu_wr(4'h2, 8'h12);
    check("ch1_base", baseAddrReg[1], 16'h1234);
    check("ch1_cur", currAddrReg[1], 16'h1234);
    cpu_rd(4'h2, d);
    check("ch1_rd_lo", d, 8'h34);
    cpu_rd(4'h2, d);
    check("ch1_rd_hi", d, 8'h12);
    cpu_wr(4'hE, 8'h00);
    check("mask_clr_all", maskReg, 8'h00);
    cpu_wr(4'h1, 8'h01);
    cpu_wr(4'h1, 8'h00);
    cpu_wr(4'h0, 8'hFF);
    cpu_wr(4'h0, 8'h00);
    cpu_wr(4'hB, 8'h00);
    upd(2'd0);
    check("ch0_u1_tcp", tc_pulse, 1'b0);
    check("ch0_u1_addr", currAddrReg[0], 16'h0100);
    upd(2'd0);
    check("ch0_u2_tcp", tc_pulse, 1'b1);
    check("ch0_u2_addr", currAddrReg[0], 16'h0101);
    check("ch0_u2_word", currWordReg[0], 16'hFFFF);
    check("ch0_mask", maskReg, 8'h01);
    check("ch0_status", statusReg, 8'hA1);
    @(negedge CLK);
    check("tcp_one_cycle", tc_pulse, 1'b0);
    cpu_rd(4'h8, d);
    check("stat_rd1", d, 8'hA1);
    cpu_rd(4'h8, d);
    check("stat_rd2", d, 8'hA0);
    cpu_wr(4'hB, 8'h32);
    check("ch2_mode", modeReg[2], 6'h0C);
    cpu_wr(4'h4, 8'h10);
    cpu_wr(4'h4, 8'h00);
    cpu_wr(4'h5, 8'h00);
    cpu_wr(4'h5, 8'h00);
    upd(2'd2);
    check("ch2_tcp", tc_pulse, 1'b1);
    check("ch2_reload_addr", currAddrReg[2], 16'h0010);
    check("ch2_reload_word", currWordReg[2], 16'h0000);
    check("ch2_mask_kept", maskReg, 8'h01);
    cpu_wr(4'h5, 8'h02);
    cpu_wr(4'h5, 8'h00);
    upd(2'd2);
    check("ch2_dec_addr", currAddrReg[2], 16'h000F);
    check("ch2_dec_word", currWordReg[2], 16'h0001);
    check("ch2_dec_tcp", tc_pulse, 1'b0);
    cpu_wr(4'hF, 8'h05);
    check("mask_all_wr", maskReg, 8'h05);
    cpu_wr(4'hA, 8'h02);
    check("mask_single", maskReg, 8'h01);
    cpu_wr(4'hE, 8'h00);
    check("mask_clear", maskReg, 8'h00);
    cpu_rd(4'hF, d);
`ifdef DMA_MASK_READBACK_EN
    check("mask_readback", d, 8'hF0);
`else
    check("mask_readback", d, 8'h00);
`endif
    cpu_wr(4'h9, 8'h07);
    check("req_set", requestReg, 8'h08);
    @(negedge CLK) bus.A = 4'h8; bus.CS_N = 1'b0; bus.IOR_N = 1'b0;
    @(negedge CLK) d = bus.DB_OUT; bus.IOR_N = 1'b1; upd_valid = 1'b1; upd_ch = 2'd3;
    @(negedge CLK) upd_valid = 1'b0; bus.CS_N = 1'b1;
    check("coll_rd_data", d, 8'hA4);
    check("coll_tcp", tc_pulse, 1'b1);
    check("coll_req", requestReg, 8'h00);
    check("coll_status", statusReg, 8'hA8);
    check("coll_mask", maskReg, 8'h08);
    cpu_wr(4'hD, 8'hFF);
    check("mclr_mask", maskReg, 8'h0F);
    check("mclr_addr", currAddrReg[1], 16'h0000);
    check("mclr_mode", modeReg[2], 6'h00);
    check("mclr_status", statusReg, 8'hA0);
    @(negedge CLK) bus.A = 4'h0; bus.DB_IN = 8'h55; bus.CS_N = 1'b0; bus.IOW_N = 1'b0;
    @(negedge CLK);
    @(negedge CLK) bus.IOW_N = 1'b1; upd_valid = 1'b1; upd_ch = 2'd0;
    @(negedge CLK) upd_valid = 1'b0; bus.CS_N = 1'b1;
    check("wr_wins_addr", currAddrReg[0], 16'h0055);
    check("wr_wins_base", baseAddrReg[0], 16'h0055);
    check("wr_wins_word", currWordReg[0], 16'hFFFF);
    cpu_wr(4'h8, 8'h5A);
    check("cmd_wr", commandReg, 8'h5A);
    @(negedge CLK) bus.A = 4'h8; bus.DB_IN = 8'h77; bus.CS_N = 1'b0; bus.IOW_N = 1'b0;
    @(negedge CLK);
    #2 RESET = 1'b1;
    #2 bus.IOW_N = 1'b1; bus.CS_N = 1'b1;
    @(negedge CLK) RESET = 1'b0;
    repeat (2) @(negedge CLK);
    check("abort_cmd", commandReg, 8'h00);
    check("abort_mask", maskReg, 8'h0F);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
